// File: rtl/systolic_pkg.sv
// Shared constants for the systolic array sequencer: default geometry,
// state encoding and PE mode values.
package systolic_pkg;

    localparam int unsigned DEF_N     = 4;
    localparam int unsigned DEF_K_MAX = 16;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_CLEAR = 3'd1;
    localparam logic [STATE_W-1:0] ST_FEED  = 3'd2;
    localparam logic [STATE_W-1:0] ST_FLUSH = 3'd3;
    localparam logic [STATE_W-1:0] ST_DRAIN = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

    localparam logic MODE_COMPUTE = 1'b0;
    localparam logic MODE_DRAIN   = 1'b1;

endpackage

// File: rtl/systolic_array_controller_if.sv
// Host / operand-buffer / PE-array control bundle of the systolic sequencer.
interface systolic_array_controller_if
    import systolic_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned K_MAX = DEF_K_MAX,
    parameter int unsigned KW    = $clog2(K_MAX + 1),
    parameter int unsigned AW    = $clog2(K_MAX),
    parameter int unsigned RW    = $clog2(N)
);

    logic          start;
    logic [KW-1:0] k_len;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  row_en;
    logic [N-1:0]  col_en;
    logic          pe_clr;
    logic          pe_mode;
    logic          drain_valid;
    logic [RW-1:0] drain_row;

    modport master (
        input  start, k_len,
        output busy, done, rd_en, rd_addr, row_en, col_en,
               pe_clr, pe_mode, drain_valid, drain_row
    );

    modport slave (
        output start, k_len,
        input  busy, done, rd_en, rd_addr, row_en, col_en,
               pe_clr, pe_mode, drain_valid, drain_row
    );

endinterface

// File: rtl/skew_delay_line.sv
// Shift register of the buffer read strobe; tap i is the input delayed 1+i cycles.
module skew_delay_line #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_en,
    output logic [N-1:0] out_en
);

    logic [N-1:0] sr_q;
    logic [N-1:0] sr_d;

    always_comb begin
        sr_d = {sr_q[N-2:0], in_en};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign out_en = sr_q;

endmodule

// File: rtl/systolic_array_controller.sv
// Sequencer for an NxN output-stationary PE array: clear, skewed operand feed,
// wavefront flush and bottom-row-first drain. Carries no datapath.
module systolic_array_controller
    import systolic_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned K_MAX = DEF_K_MAX
) (
    input  logic                        clk,
    input  logic                        rst,
    systolic_array_controller_if.master bus
);

    localparam int unsigned KW = $clog2(K_MAX + 1);
    localparam int unsigned AW = $clog2(K_MAX);
    localparam int unsigned RW = $clog2(N);
    // Step counter must reach k_len+2N-2 for the largest k_len without wrapping.
    localparam int unsigned TW = $clog2(K_MAX + 2 * N - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [TW-1:0]      t_q, t_d;
    logic [RW-1:0]      d_q, d_d;
    logic [KW-1:0]      k_q, k_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_en_q, rd_en_d;
    logic [AW-1:0]      rd_addr_q, rd_addr_d;
    logic               pe_clr_q, pe_clr_d;
    logic               pe_mode_q, pe_mode_d;
    logic               drain_valid_q, drain_valid_d;
    logic [RW-1:0]      drain_row_q, drain_row_d;

    logic [N-1:0]       row_en_w;
    logic [N-1:0]       col_en_w;

    // Next state plus outputs decoded from the next state, so every output is a flop.
    always_comb begin
        state_d       = state_q;
        t_d           = t_q;
        d_d           = d_q;
        k_d           = k_q;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        rd_en_d       = 1'b0;
        rd_addr_d     = '0;
        pe_clr_d      = 1'b0;
        pe_mode_d     = MODE_COMPUTE;
        drain_valid_d = 1'b0;
        drain_row_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && (bus.k_len != '0) && (bus.k_len <= KW'(K_MAX))) begin
                    state_d = ST_CLEAR;
                    k_d     = bus.k_len;
                    t_d     = '0;
                    d_d     = '0;
                end
            end
            ST_CLEAR: begin
                state_d = ST_FEED;
                t_d     = '0;
            end
            ST_FEED: begin
                t_d = t_q + TW'(1);
                if ((t_q + TW'(1)) == TW'(k_q)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                t_d = t_q + TW'(1);
                if (t_q == (TW'(k_q) + TW'(2 * N - 2))) begin
                    state_d = ST_DRAIN;
                    d_d     = '0;
                end
            end
            ST_DRAIN: begin
                d_d = d_q + RW'(1);
                if (d_q == RW'(N - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_DONE);
        pe_clr_d      = (state_d == ST_CLEAR);
        rd_en_d       = (state_d == ST_FEED);
        rd_addr_d     = rd_en_d ? AW'(t_d) : '0;
        drain_valid_d = (state_d == ST_DRAIN);
        pe_mode_d     = drain_valid_d ? MODE_DRAIN : MODE_COMPUTE;
        drain_row_d   = drain_valid_d ? (RW'(N - 1) - d_d) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            t_q           <= '0;
            d_q           <= '0;
            k_q           <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            pe_clr_q      <= 1'b0;
            pe_mode_q     <= MODE_COMPUTE;
            drain_valid_q <= 1'b0;
            drain_row_q   <= '0;
        end else begin
            state_q       <= state_d;
            t_q           <= t_d;
            d_q           <= d_d;
            k_q           <= k_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            pe_clr_q      <= pe_clr_d;
            pe_mode_q     <= pe_mode_d;
            drain_valid_q <= drain_valid_d;
            drain_row_q   <= drain_row_d;
        end
    end

    // Row and column feeds share the same skew; one line per array edge.
    skew_delay_line #(.N(N)) u_row_skew (
        .clk    (clk),
        .rst_n  (rst),
        .in_en  (rd_en_q),
        .out_en (row_en_w)
    );

    skew_delay_line #(.N(N)) u_col_skew (
        .clk    (clk),
        .rst_n  (rst),
        .in_en  (rd_en_q),
        .out_en (col_en_w)
    );

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.row_en      = row_en_w;
    assign bus.col_en      = col_en_w;
    assign bus.pe_clr      = pe_clr_q;
    assign bus.pe_mode     = pe_mode_q;
    assign bus.drain_valid = drain_valid_q;
    assign bus.drain_row   = drain_row_q;

endmodule

// File: doc/systolic_array_controller.md
# systolic_array_controller

Sequencer for an N×N array of `processing_element` instances.
- On `start`, runs one matrix-multiply pass over inner dimension `k_len`:
  - clears the accumulators,
  - issues A/B operand-buffer reads,
  - generates the diagonal (skewed) row/column feed enables,
  - waits for the wavefront to flush,
  - switches the array to `mode=1` for N cycles to drain results bottom row first.
- Sits between the operand buffers / host register file and the PE array. Owns every PE control line; carries no datapath.

## Interface
- `N`, 4: array dimension (rows = columns), ≥2
- `K_MAX`, 16: maximum inner dimension
- `KW`, $clog2(K_MAX+1): width of `k_len`
- `AW`, $clog2(K_MAX): buffer address width

- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: request a pass; sampled only in IDLE
- `k_len` in KW: inner dimension, sampled with `start`
- `busy` out 1: pass in progress
- `done` out 1: one-cycle pulse at end of pass
- `rd_en` out 1: A/B buffer read strobe; buffer read latency is 1 cycle
- `rd_addr` out AW: common A/B read index
- `row_en` out N: per-row A-feed valid into column 0
- `col_en` out N: per-column B-feed valid into row 0
- `pe_clr` out 1: accumulator clear to the array
- `pe_mode` out 1: drives every PE `mode` (0 = compute, 1 = shift `c` out)
- `drain_valid` out 1: array `c_out` bottom edge holds a valid row
- `drain_row` out $clog2(N): row index of the current drain data

## Operation
- **States:** IDLE → CLEAR → FEED → FLUSH → DRAIN → DONE → IDLE.
- **IDLE**
  - Go to CLEAR when `start=1` and 1 ≤ `k_len` ≤ K_MAX; latch `k_len`.
  - Out-of-range `k_len` (0 or >K_MAX): request ignored, stay in IDLE, no `done`.
- **CLEAR:** 1 cycle, `pe_clr=1`. Step counter `t` cleared to 0.
- **FEED:** `t` = 0..k_len-1.
  - `rd_en=1`, `rd_addr=t`.
  - `t` increments every cycle.
- **FLUSH:** `t` = k_len..k_len+2N-2 (2N-1 cycles).
  - `rd_en=0`.
  - Last PE[N-1][N-1] update occurs in the final FLUSH cycle.
- **Skew:**
  - `row_en[i]` = `rd_en` delayed 1+i cycles; `col_en[j]` = `rd_en` delayed 1+j cycles.
  - These delays are independent of state, so they complete during FLUSH.
- **DRAIN:** N cycles, `d` = 0..N-1.
  - `pe_mode=1`, `drain_valid=1`.
  - `drain_row = N-1-d`.
- **DONE:** 1 cycle, `done=1`, `busy=1`; next state IDLE.
- **`busy`:** 1 in every state except IDLE.
- **`start` handling:**
  - `start` in any non-IDLE state is ignored.
  - `start` held high re-arms only after one IDLE cycle.
- **Reset:** `rst=0` at any time forces IDLE immediately, clears counters and the skew delay lines.
  - Every output resets to 0, including `pe_mode=0`.
  - A pass interrupted by reset is lost; no `done`.
- **Counter widths:** `t` must hold K_MAX+2N-2 with no wrap. `rd_addr` never exceeds k_len-1.

## Timing
- Count from the `start`-sampling edge as cycle 0. Cycle numbers below are the cycles in which registered outputs are high.
  - CLEAR: cycle 1.
  - FEED: cycles 2..k_len+1.
  - FLUSH: k_len+2..k_len+2N.
  - DRAIN: k_len+2N+1..k_len+3N.
  - DONE: k_len+3N+1.
- Pass length (`busy` high): k_len+3N+1 cycles.
- `row_en[i]`: cycles 3+i..k_len+2+i.
- All outputs are registered. No combinational path from `start` to any output.

## Structure
- **Shared package `systolic_pkg`:**
  - state enum (IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE),
  - default N / K_MAX,
  - mode constants MODE_COMPUTE=0, MODE_DRAIN=1.
- **Sub-module `skew_delay_line`:**
  - parameter N; shift register of `rd_en` producing the N tapped enables;
  - asynchronous active-low reset;
  - instantiated twice (rows, columns).

## Test plan
- **Reset:** hold `rst=0` with `start=1`.
  - All outputs 0, `busy=0`.
  - Release: no activity until `start` is sampled in IDLE.
- **Nominal pass, N=4, k_len=3:**
  - `pe_clr` cycle 1; `rd_addr` 0,1,2 in cycles 2–4.
  - `row_en[0]` cycles 3–5, `row_en[3]` cycles 6–8.
  - `pe_mode` and `drain_valid` cycles 12–15 with `drain_row` 3,2,1,0.
  - `done` cycle 16; `busy` high cycles 1–16.
- **Range check:**
  - `k_len=0` or 17: ignored, `busy` stays 0, no `done`.
  - `k_len=16`: `rd_addr` reaches 15 without wrap; `done` at cycle 29.
- **`start` during a pass:**
  - Pulses in FEED and DRAIN have no effect.
  - `start` held high continuously: second CLEAR in cycle 18 (one IDLE cycle, 17, between passes).
- **Reset mid-FEED:** assert `rst=0` in cycle 3.
  - All outputs 0 immediately; `row_en` delay lines empty.
  - New `start` runs a full, correct pass.
- **End-to-end with a 4×4 PE array and buffers:** A = B = identity, k_len=4 → drained rows equal identity, bottom row first.
